sdram_port_arbiter: RTL and testbench

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM command channel between a priority ROM-download write port
// and NCH round-robin read requesters; one transaction in flight at a time.
module sdram_port_arbiter #(
    parameter int NCH = 4,
    parameter int AW  = 25,
    parameter int DW  = 16,
    parameter int TMO = 255
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                dl_active,
    input  logic                dl_req,
    input  logic [AW-1:0]       dl_addr,
    input  logic [DW-1:0]       dl_data,
    input  logic [1:0]          dl_be,
    output logic                dl_rdy,

    input  logic [NCH-1:0]      rd_req,
    input  logic [NCH*AW-1:0]   rd_addr,
    input  logic [NCH-1:0]      rd_mask,
    output logic [NCH-1:0]      rd_rdy,
    output logic [DW-1:0]       rd_dout,

    output logic [AW-1:0]       sdr_addr,
    output logic [DW-1:0]       sdr_din,
    output logic [1:0]          sdr_be,
    output logic                sdr_rnw,
    output logic                sdr_req,
    input  logic                sdr_ready,
    input  logic [DW-1:0]       sdr_dout,

    output logic                timeout_err
);

    localparam int CW = $clog2(TMO + 1);
    localparam int GW = $clog2(NCH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   pick;
    logic            pick_vld;
    logic [AW-1:0]   pick_addr;
    logic [NCH-1:0]  eligible;
    int              idx;

    logic            dl_win;
    logic            is_dl;
    logic [CW-1:0]   wait_cnt;
    logic            got_ready;
    logic            timed_out;

    assign eligible  = rd_req & ~rd_mask;
    assign dl_win    = dl_active & dl_req;
    assign got_ready = (state == WAIT) && sdr_ready;
    // The abort fires on the edge where the counter steps onto TMO.
    assign timed_out = (state == WAIT) && !sdr_ready && (wait_cnt >= CW'(TMO - 1));

    // Search starts one past the last winner so every channel gets a turn.
    always_comb begin
        pick      = last_grant;
        pick_vld  = 1'b0;
        pick_addr = '0;
        idx       = 0;
        for (int i = 1; i <= NCH; i++) begin
            idx = (int'(last_grant) + i) % NCH;
            if (!pick_vld && eligible[idx]) begin
                pick      = GW'(idx);
                pick_vld  = 1'b1;
                pick_addr = rd_addr[idx*AW +: AW];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dl_win || pick_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (got_ready || timed_out) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant  <= GW'(NCH - 1);
            is_dl       <= 1'b0;
            sdr_req     <= 1'b0;
            sdr_addr    <= '0;
            sdr_din     <= '0;
            sdr_be      <= 2'b00;
            sdr_rnw     <= 1'b1;
            dl_rdy      <= 1'b0;
            rd_rdy      <= '0;
            rd_dout     <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            sdr_req <= 1'b0;
            dl_rdy  <= 1'b0;
            rd_rdy  <= '0;
            case (state)
                IDLE: begin
                    if (dl_win) begin
                        is_dl    <= 1'b1;
                        sdr_addr <= dl_addr;
                        sdr_din  <= dl_data;
                        sdr_be   <= dl_be;
                        sdr_rnw  <= 1'b0;
                        sdr_req  <= 1'b1;
                    end else if (pick_vld) begin
                        is_dl      <= 1'b0;
                        last_grant <= pick;
                        sdr_addr   <= pick_addr;
                        sdr_be     <= 2'b11;
                        sdr_rnw    <= 1'b1;
                        sdr_req    <= 1'b1;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (wait_cnt != CW'(TMO))
                        wait_cnt <= wait_cnt + CW'(1);
                    if (got_ready || timed_out) begin
                        if (is_dl)
                            dl_rdy <= 1'b1;
                        else begin
                            rd_rdy[last_grant] <= 1'b1;
                            rd_dout            <= got_ready ? sdr_dout : '0;
                        end
                        if (timed_out)
                            timeout_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: reset values, latency, round-robin,
// download priority, masking, timeout and reset during a transaction.
module tb_sdram_port_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 25;
    localparam int DW  = 16;
    localparam int TMO = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               dl_active, dl_req;
    logic [AW-1:0]      dl_addr;
    logic [DW-1:0]      dl_data;
    logic [1:0]         dl_be;
    logic               dl_rdy;
    logic [NCH-1:0]     rd_req, rd_mask, rd_rdy;
    logic [NCH*AW-1:0]  rd_addr;
    logic [DW-1:0]      rd_dout;
    logic [AW-1:0]      sdr_addr;
    logic [DW-1:0]      sdr_din;
    logic [1:0]         sdr_be;
    logic               sdr_rnw, sdr_req, sdr_ready;
    logic [DW-1:0]      sdr_dout;
    logic               timeout_err;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .TMO(TMO)) dut (
        .clk(clk), .reset(reset),
        .dl_active(dl_active), .dl_req(dl_req), .dl_addr(dl_addr),
        .dl_data(dl_data), .dl_be(dl_be), .dl_rdy(dl_rdy),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_mask(rd_mask),
        .rd_rdy(rd_rdy), .rd_dout(rd_dout),
        .sdr_addr(sdr_addr), .sdr_din(sdr_din), .sdr_be(sdr_be),
        .sdr_rnw(sdr_rnw), .sdr_req(sdr_req), .sdr_ready(sdr_ready),
        .sdr_dout(sdr_dout), .timeout_err(timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for the command strobe.
    task automatic wait_req(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sdr_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // Downstream model: ready pulse d cycles after the strobe cycle.
    task automatic respond(input int d, input logic [DW-1:0] data);
        repeat (d) tick();
        sdr_ready = 1'b1;
        sdr_dout  = data;
        tick();
        sdr_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        vectors++; if (sdr_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sdr_req got %b want 0", sdr_req); end
        vectors++; if (sdr_rnw !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_sdr_rnw got %b want 1", sdr_rnw); end
        vectors++; if (sdr_addr !== '0) begin miscompares++; $display("[TB] FAIL reset_sdr_addr got %h want 0", sdr_addr); end
        vectors++; if (sdr_din !== '0 || sdr_be !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_din_be got %h/%b want 0/00", sdr_din, sdr_be); end
        vectors++; if (rd_rdy !== '0 || dl_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rdy got %b/%b want 0000/0", rd_rdy, dl_rdy); end
        vectors++; if (rd_dout !== '0 || timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_dout_err got %h/%b want 0/0", rd_dout, timeout_err); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        rd_addr[2*AW +: AW] = 25'h00_1234;
        rd_req = 4'b0100;
        tick();
        vectors++; if (sdr_req !== 1'b1) begin miscompares++; $display("[TB] FAIL single_latency sdr_req got %b want 1", sdr_req); end
        vectors++; if (sdr_addr !== 25'h00_1234) begin miscompares++; $display("[TB] FAIL single_addr got %h want 0001234", sdr_addr); end
        vectors++; if (sdr_rnw !== 1'b1 || sdr_be !== 2'b11) begin miscompares++; $display("[TB] FAIL single_rnw_be got %b/%b want 1/11", sdr_rnw, sdr_be); end
        tick();
        vectors++; if (sdr_req !== 1'b0) begin miscompares++; $display("[TB] FAIL single_one_pulse got %b want 0", sdr_req); end
        repeat (4) tick();
        vectors++; if (rd_rdy !== 4'b0000) begin miscompares++; $display("[TB] FAIL single_early_rdy got %b want 0000", rd_rdy); end
        sdr_ready = 1'b1;
        sdr_dout  = 16'hBEEF;
        tick();
        sdr_ready = 1'b0;
        vectors++; if (rd_rdy !== 4'b0100) begin miscompares++; $display("[TB] FAIL single_rdy got %b want 0100", rd_rdy); end
        vectors++; if (rd_dout !== 16'hBEEF) begin miscompares++; $display("[TB] FAIL single_dout got %h want BEEF", rd_dout); end
        vectors++; if (sdr_addr !== 25'h00_1234) begin miscompares++; $display("[TB] FAIL single_addr_stable got %h want 0001234", sdr_addr); end
        rd_req = '0;
        tick();
        vectors++; if (rd_rdy !== 4'b0000 || rd_dout !== 16'hBEEF) begin miscompares++; $display("[TB] FAIL single_after got %b/%h want 0000/BEEF", rd_rdy, rd_dout); end
    endtask

    task automatic test_round_robin();
        bit             seen;
        int             exp;
        logic [AW-1:0]  ea;
        logic [NCH-1:0] er;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NCH; i++) rd_addr[i*AW +: AW] = AW'(32'h100 * (i + 1));
        rd_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp = k % NCH;
            ea  = AW'(32'h100 * (exp + 1));
            er  = 4'b0001 << exp;
            wait_req(seen);
            vectors++; if (!seen) begin miscompares++; $display("[TB] FAIL rr_timeout grant %0d got no sdr_req want sdr_req", k); end
            vectors++; if (sdr_addr !== ea) begin miscompares++; $display("[TB] FAIL rr_order grant %0d got addr %h want %h", k, sdr_addr, ea); end
            respond(2, DW'(16'hA000 + k));
            vectors++; if (rd_rdy !== er) begin miscompares++; $display("[TB] FAIL rr_rdy grant %0d got %b want %b", k, rd_rdy, er); end
            vectors++; if (rd_dout !== DW'(16'hA000 + k)) begin miscompares++; $display("[TB] FAIL rr_dout grant %0d got %h want %h", k, rd_dout, DW'(16'hA000 + k)); end
            if (k == 4) rd_req = '0;
            else        rd_req[exp] = 1'b0;
            tick();
            if (k != 4) rd_req[exp] = 1'b1;
        end
        tick();
    endtask

    task automatic test_download_priority();
        bit seen;
        rd_addr[0*AW +: AW] = 25'h0AA;
        rd_addr[1*AW +: AW] = 25'h0BB;
        dl_active = 1'b1;
        dl_req    = 1'b1;
        dl_addr   = 25'h1ABCDE;
        dl_data   = 16'h5A5A;
        dl_be     = 2'b01;
        rd_req    = 4'b0011;
        wait_req(seen);
        vectors++; if (!seen) begin miscompares++; $display("[TB] FAIL dl_timeout got no sdr_req want sdr_req"); end
        vectors++; if (sdr_rnw !== 1'b0 || sdr_be !== 2'b01) begin miscompares++; $display("[TB] FAIL dl_rnw_be got %b/%b want 0/01", sdr_rnw, sdr_be); end
        vectors++; if (sdr_addr !== 25'h1ABCDE || sdr_din !== 16'h5A5A) begin miscompares++; $display("[TB] FAIL dl_fields got %h/%h want 1abcde/5a5a", sdr_addr, sdr_din); end
        dl_active = 1'b0;
        respond(3, 16'h7777);
        vectors++; if (dl_rdy !== 1'b1 || rd_rdy !== 4'b0000) begin miscompares++; $display("[TB] FAIL dl_rdy got %b/%b want 1/0000", dl_rdy, rd_rdy); end
        vectors++; if (rd_dout !== 16'hA004) begin miscompares++; $display("[TB] FAIL dl_dout_kept got %h want A004", rd_dout); end
        dl_req = 1'b0;
        wait_req(seen);
        vectors++; if (!seen || sdr_addr !== 25'h0BB || sdr_rnw !== 1'b1) begin miscompares++; $display("[TB] FAIL dl_then_rd1 got seen=%b addr=%h rnw=%b want 1/0bb/1", seen, sdr_addr, sdr_rnw); end
        vectors++; if (sdr_din !== 16'h5A5A) begin miscompares++; $display("[TB] FAIL rd_din_unchanged got %h want 5a5a", sdr_din); end
        respond(1, 16'h1001);
        vectors++; if (rd_rdy !== 4'b0010 || dl_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL dl_rd1_rdy got %b/%b want 0010/0", rd_rdy, dl_rdy); end
        rd_req[1] = 1'b0;
        wait_req(seen);
        vectors++; if (!seen || sdr_addr !== 25'h0AA) begin miscompares++; $display("[TB] FAIL dl_then_rd0 got seen=%b addr=%h want 1/0aa", seen, sdr_addr); end
        respond(1, 16'h1000);
        vectors++; if (rd_rdy !== 4'b0001 || rd_dout !== 16'h1000) begin miscompares++; $display("[TB] FAIL dl_rd0_rdy got %b/%h want 0001/1000", rd_rdy, rd_dout); end
        rd_req = '0;
        tick();
    endtask

    task automatic test_mask();
        bit seen;
        int bad;
        bad     = 0;
        rd_mask = 4'b0001;
        rd_req  = 4'b0001;
        repeat (50) begin
            tick();
            if (sdr_req !== 1'b0) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("[TB] FAIL mask_block got %0d strobes want 0", bad); end
        rd_mask = 4'b0000;
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (sdr_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++; if (!seen || sdr_addr !== 25'h0AA) begin miscompares++; $display("[TB] FAIL mask_release got seen=%b addr=%h want 1/0aa", seen, sdr_addr); end
        respond(1, 16'h1111);
        vectors++; if (rd_rdy !== 4'b0001 || rd_dout !== 16'h1111) begin miscompares++; $display("[TB] FAIL mask_rdy got %b/%h want 0001/1111", rd_rdy, rd_dout); end
        rd_req = '0;
        tick();
    endtask

    task automatic test_timeout();
        bit seen;
        bit got;
        int cnt;
        int bad;
        rd_addr[2*AW +: AW] = 25'h00_1234;
        vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL tmo_err_pre got %b want 0", timeout_err); end
        rd_req = 4'b0100;
        wait_req(seen);
        vectors++; if (!seen) begin miscompares++; $display("[TB] FAIL tmo_start got no sdr_req want sdr_req"); end
        cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cnt++;
            if (rd_rdy !== 4'b0000) begin
                got = 1'b1;
                break;
            end
        end
        vectors++; if (!got || cnt != 9) begin miscompares++; $display("[TB] FAIL tmo_latency got %0d cycles (seen=%b) want 9", cnt, got); end
        vectors++; if (rd_rdy !== 4'b0100 || rd_dout !== '0) begin miscompares++; $display("[TB] FAIL tmo_rdy_dout got %b/%h want 0100/0000", rd_rdy, rd_dout); end
        vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_err got %b want 1", timeout_err); end
        rd_req = '0;
        tick();
        sdr_ready = 1'b1;
        sdr_dout  = 16'hDEAD;
        tick();
        sdr_ready = 1'b0;
        bad = 0;
        repeat (5) begin
            if (rd_rdy !== '0 || dl_rdy !== 1'b0 || sdr_req !== 1'b0 || rd_dout !== '0) bad++;
            tick();
        end
        vectors++; if (bad != 0) begin miscompares++; $display("[TB] FAIL tmo_late_ready got %0d bad cycles want 0", bad); end
        vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_sticky got %b want 1", timeout_err); end
    endtask

    task automatic test_reset_during_wait();
        bit seen;
        int bad;
        rd_req = 4'b0010;
        wait_req(seen);
        vectors++; if (!seen || sdr_addr !== 25'h0BB) begin miscompares++; $display("[TB] FAIL rstw_start got seen=%b addr=%h want 1/0bb", seen, sdr_addr); end
        repeat (2) tick();
        #2 reset = 1'b1;
        #1;
        vectors++; if (sdr_addr !== '0 || sdr_rnw !== 1'b1 || sdr_be !== 2'b00) begin miscompares++; $display("[TB] FAIL rstw_fields got %h/%b/%b want 0/1/00", sdr_addr, sdr_rnw, sdr_be); end
        vectors++; if (timeout_err !== 1'b0 || rd_dout !== '0 || sdr_din !== '0) begin miscompares++; $display("[TB] FAIL rstw_err_dout got %b/%h/%h want 0/0/0", timeout_err, rd_dout, sdr_din); end
        tick();
        reset  = 1'b0;
        rd_req = '0;
        sdr_ready = 1'b1;
        sdr_dout  = 16'hCAFE;
        tick();
        sdr_ready = 1'b0;
        bad = 0;
        repeat (8) begin
            if (rd_rdy !== '0 || dl_rdy !== 1'b0 || sdr_req !== 1'b0) bad++;
            tick();
        end
        vectors++; if (bad != 0) begin miscompares++; $display("[TB] FAIL rstw_no_rdy got %0d bad cycles want 0", bad); end
        vectors++; if (rd_dout !== '0) begin miscompares++; $display("[TB] FAIL rstw_dout_after got %h want 0", rd_dout); end
    endtask

    initial begin
        reset     = 1'b1;
        dl_active = 1'b0;
        dl_req    = 1'b0;
        dl_addr   = '0;
        dl_data   = '0;
        dl_be     = 2'b00;
        rd_req    = '0;
        rd_addr   = '0;
        rd_mask   = '0;
        sdr_ready = 1'b0;
        sdr_dout  = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_download_priority();
        test_mask();
        test_timeout();
        test_reset_during_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation ran past 500000 ns");
        $fatal(1, "[TB] watchdog");
    end

endmodule
